// File: rtl/countx_pkg.sv
// Shared definitions for the countx scan controller: default data width and FSM state encoding.
package countx_pkg;

    localparam int SIZE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READ,
        ST_CMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/countx_counter.sv
// Generic up/down counter with synchronous load; load has priority over inc, inc over dec.
module countx_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    // NOTE: no reset here on purpose; the owner always loads the counter before its value is used.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + W'(1);
        end else if (dec) begin
            q <= q - W'(1);
        end
    end

endmodule

// File: rtl/countx_ctrl.sv
// Scans len memory entries starting at address 0 and reports how many of them equal target.
module countx_ctrl #(
    parameter int SIZE = countx_pkg::SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] len,
    input  logic [SIZE-1:0] target,
    output logic            mem_rd,
    output logic [SIZE-1:0] mem_addr,
    input  logic [SIZE-1:0] mem_data,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] count
);

    import countx_pkg::*;

    state_t          state_q;
    state_t          state_d;
    logic [SIZE-1:0] len_q;
    logic [SIZE-1:0] target_q;
    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] i_q;
    logic [SIZE-1:0] tr_q;
    logic            capture;
    logic            i_load;
    logic            i_inc;
    logic            tr_load;
    logic            tr_inc;

    countx_counter #(.W(SIZE)) u_i (
        .clk  (clk),
        .load (i_load),
        .d    ('0),
        .inc  (i_inc),
        .dec  (1'b0),
        .q    (i_q)
    );

    countx_counter #(.W(SIZE)) u_tr (
        .clk  (clk),
        .load (tr_load),
        .d    ('0),
        .inc  (tr_inc),
        .dec  (1'b0),
        .q    (tr_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                len_q    <= len;
                target_q <= target;
            end
            if (state_q == ST_DONE) begin
                count_q <= tr_q;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_d = state_q;
        capture = 1'b0;
        i_load  = 1'b0;
        i_inc   = 1'b0;
        tr_load = 1'b0;
        tr_inc  = 1'b0;
        mem_rd  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                i_load  = 1'b1;
                tr_load = 1'b1;
                state_d = (len_q == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                mem_rd  = 1'b1;
                state_d = ST_CMP;
            end
            ST_CMP: begin
                tr_inc = (mem_data == target_q);
                // len_q is at least 1 here, so len_q-1 cannot wrap.
                if (i_q == len_q - SIZE'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    i_inc   = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign mem_addr = i_q;
    assign count    = count_q;

endmodule

// File: tb/tb_countx_ctrl.sv
// Self-checking bench for countx_ctrl: directed vector table, corner sequences and random scans vs a model.
module tb_countx_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] len      = '0;
    logic [7:0] target   = '0;
    logic [7:0] mem_data = '0;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       busy;
    logic       done;
    logic [7:0] count;

    logic [7:0] mem [256];

    int tests = 0;
    int fails = 0;

    countx_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .target   (target),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    typedef struct {
        int         pat;
        int         n;
        logic [7:0] tgt;
        int         exp_count;
        int         exp_cyc;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic fill_mem(input int pat, input logic [7:0] tgt);
        for (int k = 0; k < 256; k++) begin
            case (pat)
                0:       mem[k] = 8'd0;
                1:       mem[k] = tgt;
                default: mem[k] = 8'(k);
            endcase
        end
        if (pat == 0) begin
            mem[0] = 8'd5;
            mem[1] = 8'd3;
            mem[2] = 8'd5;
            mem[3] = 8'd5;
        end
    endtask

    function automatic int model_count(input int n, input logic [7:0] tgt);
        int c = 0;
        for (int k = 0; k < n; k++) begin
            if (mem[k] == tgt) c++;
        end
        return c;
    endfunction

    function automatic int model_cycle(input int n);
        return (n == 0) ? 2 : 2 * n + 2;
    endfunction

    // Starts a scan from the current cycle; cycle 0 is the one whose edge samples start.
    // ra/rb: cycles in which start is re-asserted with scrambled len/target (expected to be ignored).
    // Returns in the IDLE cycle after done, with got_cnt sampled there.
    task automatic run_scan(input int n, input logic [7:0] tgt, input int ra, input int rb,
                            input int prev_cnt, output int done_cyc, output int rd_n,
                            output int addr_ok, output int stable, output int got_cnt);
        int cyc;
        done_cyc = -1;
        rd_n     = 0;
        addr_ok  = 1;
        stable   = 1;
        got_cnt  = -1;
        len      = 8'(n);
        target   = tgt;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc <= 600) begin
            if (cyc == ra || cyc == rb) begin
                start  = 1'b1;
                len    = ~len;
                target = ~target;
            end else begin
                start = 1'b0;
            end
            if (mem_rd) begin
                if (int'(mem_addr) != rd_n) addr_ok = 0;
                rd_n++;
            end
            if (int'(count) != prev_cnt) stable = 0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (done_cyc >= 0) begin
            @(posedge clk);
            #1;
            start   = 1'b0;
            got_cnt = int'(count);
        end else begin
            start = 1'b0;
        end
    endtask

    initial begin
        int dc, rdn, aok, stb, cnt, exp_prev, exp, n;
        logic [7:0] tgt;

        vecs[0] = '{0,   4, 8'd5,   3,  10};
        vecs[1] = '{0,   0, 8'd5,   0,   2};
        vecs[2] = '{0,   4, 8'd3,   1,  10};
        vecs[3] = '{0,   1, 8'd5,   1,   4};
        vecs[4] = '{0,   2, 8'd3,   1,   6};
        vecs[5] = '{0,   6, 8'd0,   2,  14};
        vecs[6] = '{1, 255, 8'hA7, 255, 512};
        vecs[7] = '{2, 255, 8'd254,  1, 512};
        vecs[8] = '{2, 255, 8'd255,  0, 512};
        vecs[9] = '{2,   1, 8'd0,   1,   4};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   int'(busy),   0);
        check("rst_done",   int'(done),   0);
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_count",  int'(count),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        exp_prev = 0;
        for (int v = 0; v < 10; v++) begin
            fill_mem(vecs[v].pat, vecs[v].tgt);
            run_scan(vecs[v].n, vecs[v].tgt, -1, -1, exp_prev, dc, rdn, aok, stb, cnt);
            check($sformatf("vec%0d_done_cycle", v), dc,  vecs[v].exp_cyc);
            check($sformatf("vec%0d_count", v),      cnt, vecs[v].exp_count);
            check($sformatf("vec%0d_rd_pulses", v),  rdn, vecs[v].n);
            check($sformatf("vec%0d_addr_seq", v),   aok, 1);
            check($sformatf("vec%0d_count_hold", v), stb, 1);
            check($sformatf("vec%0d_idle", v),       int'(busy), 0);
            exp_prev = vecs[v].exp_count;
        end

        // start pulsed while busy, with scrambled len/target: ignored, single done.
        fill_mem(0, 8'd0);
        run_scan(4, 8'd5, 3, 5, exp_prev, dc, rdn, aok, stb, cnt);
        check("busy_start_done_cycle", dc,  10);
        check("busy_start_count",      cnt, 3);
        check("busy_start_count_hold", stb, 1);
        check("busy_start_rd_pulses",  rdn, 4);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("busy_start_no_second_done", int'(done), 0);
            check("busy_start_stays_idle",     int'(busy), 0);
        end
        exp_prev = 3;

        // start asserted only in the DONE cycle: ignored.
        run_scan(4, 8'd3, 10, -1, exp_prev, dc, rdn, aok, stb, cnt);
        check("done_start_done_cycle", dc,  10);
        check("done_start_count",      cnt, 1);
        @(posedge clk);
        #1;
        check("done_start_ignored", int'(busy), 0);
        exp_prev = 1;

        // Back-to-back scans: second start in the IDLE cycle right after the first done.
        run_scan(4, 8'd5, -1, -1, exp_prev, dc, rdn, aok, stb, cnt);
        check("b2b_first_count", cnt, 3);
        check("b2b_first_cycle", dc,  10);
        run_scan(4, 8'd3, -1, -1, 3, dc, rdn, aok, stb, cnt);
        check("b2b_second_count", cnt, 1);
        check("b2b_second_cycle", dc,  10);
        check("b2b_second_hold",  stb, 1);

        // Reset in cycle 5 of a scan.
        len    = 8'd4;
        target = 8'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midscan_busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midscan_rst_busy",   int'(busy),   0);
        check("midscan_rst_mem_rd", int'(mem_rd), 0);
        check("midscan_rst_count",  int'(count),  0);
        check("midscan_rst_done",   int'(done),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", int'(busy), 0);
        run_scan(4, 8'd5, -1, -1, 0, dc, rdn, aok, stb, cnt);
        check("post_rst_count", cnt, 3);
        check("post_rst_cycle", dc,  10);
        exp_prev = 3;

        // Random scans against the model.
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < 256; k++) mem[k] = 8'($urandom_range(0, 3));
            n   = (r % 5 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            tgt = 8'($urandom_range(0, 3));
            exp = model_count(n, tgt);
            run_scan(n, tgt, -1, -1, exp_prev, dc, rdn, aok, stb, cnt);
            check($sformatf("rnd%0d_count", r),      cnt, exp);
            check($sformatf("rnd%0d_done_cycle", r), dc,  model_cycle(n));
            check($sformatf("rnd%0d_rd_pulses", r),  rdn, n);
            check($sformatf("rnd%0d_addr_seq", r),   aok, 1);
            check($sformatf("rnd%0d_count_hold", r), stb, 1);
            exp_prev = exp;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
